// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with branch bubbles and multiplier interlock
// Optional feature macro: DECODE_STALL_CNT_EN (stall-cycle counter on StallCnt; tied to zero when undefined)
module decode_stage #(
  parameter int INSTR_W    = 16,
  parameter int BR_BUBBLES = 2,
  parameter int MUL_LAT    = 3,
  localparam int F         = (INSTR_W - 4) / 3
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Flush,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [3:0]         OpCode,
  output logic [F-1:0]       OpC,
  output logic [F-1:0]       OpB,
  output logic [F-1:0]       OpA,
  output logic [INSTR_W-5:0] AddrImm,
  output logic [3:0]         OpULA,
  output logic               IsImm,
  output logic               HasWB,
  output logic               IsJump,
  output logic               IsBranch,
  output logic               IsMult,
  output logic               HiLo,
  output logic               StoreHiLo,
  output logic               MulBusy,
  output logic [15:0]        StallCnt
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLTI = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_ORI  = 4'd7;
  localparam logic [3:0] OP_XORI = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_SUBI = 4'd10;
  localparam logic [3:0] OP_J    = 4'd11;
  localparam logic [3:0] OP_BEZ  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_GHI  = 4'd14;
  localparam logic [3:0] OP_GLO  = 4'd15;

  localparam logic [3:0] ULA_ADD = 4'd0;
  localparam logic [3:0] ULA_SUB = 4'd1;
  localparam logic [3:0] ULA_SLT = 4'd2;
  localparam logic [3:0] ULA_AND = 4'd3;
  localparam logic [3:0] ULA_OR  = 4'd4;
  localparam logic [3:0] ULA_XOR = 4'd5;
  localparam logic [3:0] ULA_BEZ = 4'd6;
  localparam logic [3:0] ULA_NOP = 4'd7;

  localparam logic [3:0] BUB_INIT = 4'(BR_BUBBLES);
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT);

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

  state_t             r_state;
  logic [3:0]         r_bub_cnt;
  logic [3:0]         r_mul_cnt;
  logic               r_out_valid;
  logic [3:0]         r_opcode;
  logic [F-1:0]       r_opc;
  logic [F-1:0]       r_opb;
  logic [F-1:0]       r_opa;
  logic [INSTR_W-5:0] r_addr_imm;
  logic [3:0]         r_op_ula;
  logic               r_is_imm;
  logic               r_has_wb;
  logic               r_is_jump;
  logic               r_is_branch;
  logic               r_is_mult;
  logic               r_hilo;
  logic               r_store_hilo;

  logic [3:0]         w_op;
  logic [3:0]         w_ula;
  logic               w_is_imm;
  logic               w_has_wb;
  logic               w_hazard;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_ctrl_xfer;

  assign w_op        = Instr[INSTR_W-1 -: 4];
  assign w_hazard    = (r_mul_cnt != 4'd0) &&
                       ((w_op == OP_MUL) || (w_op == OP_GHI) || (w_op == OP_GLO));
  // Flush blocks capture so a wrong-path word fetched alongside the redirect is dropped
  assign w_in_ready  = (~r_out_valid | OutReady) & (r_state == ST_RUN) & ~w_hazard & ~Flush;
  assign w_accept    = InValid & w_in_ready;
  assign w_ctrl_xfer = (w_op == OP_J) || (w_op == OP_BEZ);

  // Opcode to ALU-op, immediate and write-back flags for the word currently on Instr
  always_comb begin
    w_ula    = ULA_NOP;
    w_is_imm = 1'b0;
    w_has_wb = 1'b1;
    case (w_op)
      OP_ADD:  w_ula = ULA_ADD;
      OP_SUB:  w_ula = ULA_SUB;
      OP_SLTI: begin w_ula = ULA_SLT; w_is_imm = 1'b1; end
      OP_AND:  w_ula = ULA_AND;
      OP_OR:   w_ula = ULA_OR;
      OP_XOR:  w_ula = ULA_XOR;
      OP_ANDI: begin w_ula = ULA_AND; w_is_imm = 1'b1; end
      OP_ORI:  begin w_ula = ULA_OR;  w_is_imm = 1'b1; end
      OP_XORI: begin w_ula = ULA_XOR; w_is_imm = 1'b1; end
      OP_ADDI: begin w_ula = ULA_ADD; w_is_imm = 1'b1; end
      OP_SUBI: begin w_ula = ULA_SUB; w_is_imm = 1'b1; end
      OP_J:    begin w_ula = ULA_NOP; w_has_wb = 1'b0; end
      OP_BEZ:  begin w_ula = ULA_BEZ; w_has_wb = 1'b0; end
      OP_MUL:  begin w_ula = ULA_NOP; w_has_wb = 1'b0; end
      default: w_ula = ULA_NOP;
    endcase
  end

  // Output pipeline register: load on accept, drop on consume or Flush, otherwise hold
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_out_valid  <= 1'b0;
      r_opcode     <= '0;
      r_opc        <= '0;
      r_opb        <= '0;
      r_opa        <= '0;
      r_addr_imm   <= '0;
      r_op_ula     <= ULA_NOP;
      r_is_imm     <= 1'b0;
      r_has_wb     <= 1'b0;
      r_is_jump    <= 1'b0;
      r_is_branch  <= 1'b0;
      r_is_mult    <= 1'b0;
      r_hilo       <= 1'b0;
      r_store_hilo <= 1'b0;
    end else if (Flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_opcode     <= w_op;
      r_opc        <= Instr[INSTR_W-5 -: F];
      r_opb        <= Instr[INSTR_W-5-F -: F];
      r_opa        <= Instr[F-1:0];
      r_addr_imm   <= Instr[INSTR_W-5:0];
      r_op_ula     <= w_ula;
      r_is_imm     <= w_is_imm;
      r_has_wb     <= w_has_wb;
      r_is_jump    <= (w_op == OP_J);
      r_is_branch  <= (w_op == OP_BEZ);
      r_is_mult    <= (w_op == OP_MUL);
      r_hilo       <= (w_op == OP_GHI);
      r_store_hilo <= (w_op == OP_GHI) || (w_op == OP_GLO);
    end else if (r_out_valid && OutReady) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Control-transfer bubble FSM: block input for BR_BUBBLES cycles after J/BEZ unless flushed
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= ST_RUN;
      r_bub_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && w_ctrl_xfer) begin
            r_state   <= ST_BUBBLE;
            r_bub_cnt <= BUB_INIT;
          end
        end
        ST_BUBBLE: begin
          if (Flush || (r_bub_cnt == 4'd1)) begin
            r_state   <= ST_RUN;
            r_bub_cnt <= 4'd0;
          end else begin
            r_bub_cnt <= r_bub_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_bub_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Multiplier latency counter; Flush leaves it alone because the multiply still completes
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_mul_cnt <= 4'd0;
    end else if (w_accept && (w_op == OP_MUL)) begin
      r_mul_cnt <= MUL_INIT;
    end else if (r_mul_cnt != 4'd0) begin
      r_mul_cnt <= r_mul_cnt - 4'd1;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles where fetch offered a word that was not taken
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_stall_cnt <= 16'h0000;
    end else if (InValid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign StallCnt = r_stall_cnt;
`else
  assign StallCnt = 16'h0000;
`endif

  assign InReady   = w_in_ready;
  assign OutValid  = r_out_valid;
  assign OpCode    = r_opcode;
  assign OpC       = r_opc;
  assign OpB       = r_opb;
  assign OpA       = r_opa;
  assign AddrImm   = r_addr_imm;
  assign OpULA     = r_op_ula;
  assign IsImm     = r_is_imm;
  assign HasWB     = r_has_wb;
  assign IsJump    = r_is_jump;
  assign IsBranch  = r_is_branch;
  assign IsMult    = r_is_mult;
  assign HiLo      = r_hilo;
  assign StoreHiLo = r_store_hilo;
  assign MulBusy   = (r_mul_cnt != 4'd0);

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a cycle-level behavioural model
module tb_decode_stage;

  localparam int BR_BUBBLES = 2;
  localparam int MUL_LAT    = 3;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  c;
    logic [3:0]  b;
    logic [3:0]  a;
    logic [11:0] imm;
    logic [3:0]  ula;
    logic        is_imm;
    logic        has_wb;
    logic        is_jump;
    logic        is_branch;
    logic        is_mult;
    logic        hilo;
    logic        store_hilo;
  } dec_t;

  logic        Clk;
  logic        nReset;
  logic        InValid;
  logic        InReady;
  logic [15:0] Instr;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  OpCode;
  logic [3:0]  OpC;
  logic [3:0]  OpB;
  logic [3:0]  OpA;
  logic [11:0] AddrImm;
  logic [3:0]  OpULA;
  logic        IsImm;
  logic        HasWB;
  logic        IsJump;
  logic        IsBranch;
  logic        IsMult;
  logic        HiLo;
  logic        StoreHiLo;
  logic        MulBusy;
  logic [15:0] StallCnt;

  dec_t obs;
  assign obs = {OpCode, OpC, OpB, OpA, AddrImm, OpULA,
                IsImm, HasWB, IsJump, IsBranch, IsMult, HiLo, StoreHiLo};

  int   total = 0;
  int   bad   = 0;

  // model state: output valid, remaining blocked bubble cycles, remaining multiply cycles, stalls
  int   m_ov;
  int   m_bub;
  int   m_mul;
  int   m_stall;
  dec_t m_out;
  bit   m_ready;

  decode_stage #(.INSTR_W(16), .BR_BUBBLES(BR_BUBBLES), .MUL_LAT(MUL_LAT)) dut (
    .Clk(Clk), .nReset(nReset), .InValid(InValid), .InReady(InReady), .Instr(Instr),
    .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady), .OpCode(OpCode),
    .OpC(OpC), .OpB(OpB), .OpA(OpA), .AddrImm(AddrImm), .OpULA(OpULA),
    .IsImm(IsImm), .HasWB(HasWB), .IsJump(IsJump), .IsBranch(IsBranch), .IsMult(IsMult),
    .HiLo(HiLo), .StoreHiLo(StoreHiLo), .MulBusy(MulBusy), .StallCnt(StallCnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic dec_t reset_dec();
    dec_t d;
    d = '0;
    d.ula = 4'd7;
    return d;
  endfunction

  function automatic dec_t ref_decode(input logic [15:0] w);
    dec_t d;
    int   op;
    op           = int'(w[15:12]);
    d.op         = w[15:12];
    d.c          = w[11:8];
    d.b          = w[7:4];
    d.a          = w[3:0];
    d.imm        = w[11:0];
    d.is_imm     = (op == 2) || (op >= 6 && op <= 10);
    d.has_wb     = (op <= 10) || (op >= 14);
    d.is_jump    = (op == 11);
    d.is_branch  = (op == 12);
    d.is_mult    = (op == 13);
    d.hilo       = (op == 14);
    d.store_hilo = (op >= 14);
    if (op <= 5)       d.ula = 4'(op);
    else if (op <= 8)  d.ula = 4'(op - 3);
    else if (op <= 10) d.ula = 4'(op - 9);
    else if (op == 12) d.ula = 4'd6;
    else               d.ula = 4'd7;
    return d;
  endfunction

  task automatic model_reset();
    m_ov    = 0;
    m_bub   = 0;
    m_mul   = 0;
    m_stall = 0;
    m_out   = reset_dec();
  endtask

  // present inputs (called at the falling edge) and predict whether the word is taken
  task automatic drive(input bit v, input logic [15:0] w, input bit ordy, input bit fl);
    InValid  = v;
    Instr    = w;
    OutReady = ordy;
    Flush    = fl;
    #1;
    m_ready = nReset && (m_ov == 0 || ordy) && (m_bub == 0) &&
              !(m_mul > 0 && w[15:12] >= 4'd13) && !fl;
  endtask

  // advance one clock, update the model, return at the next falling edge
  task automatic tick();
    bit acc;
    @(posedge Clk);
    if (nReset) begin
      acc = InValid && m_ready;
`ifdef DECODE_STALL_CNT_EN
      if (InValid && !m_ready && m_stall < 65535) m_stall++;
`endif
      if (m_mul > 0) m_mul--;
      if (acc && Instr[15:12] == 4'd13) m_mul = MUL_LAT;
      if (m_bub > 0) m_bub--;
      if (Flush) begin
        m_ov  = 0;
        m_bub = 0;
      end else if (acc) begin
        m_ov  = 1;
        m_out = ref_decode(Instr);
        if (Instr[15:12] == 4'd11 || Instr[15:12] == 4'd12) m_bub = BR_BUBBLES;
      end else if (m_ov != 0 && OutReady) begin
        m_ov = 0;
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    nReset = 1'b0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0; Instr = '0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    total++;
    if (OutValid !== 1'b0 || obs !== reset_dec() || MulBusy !== 1'b0 || StallCnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b fields=%h mulbusy=%b stall=%h want valid=0 fields=%h",
               OutValid, obs, MulBusy, StallCnt, reset_dec());
    end
    nReset = 1'b1;
    drive(1, 16'h1234, 1, 0);
    total++;
    if (InReady !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", InReady);
    end
    tick();
    drive(1, 16'hD021, 1, 0);
    tick();
    total++;
    if (MulBusy !== 1'b1 || OutValid !== 1'b1) begin
      bad++; $display("FAIL reset_pre_mul: mulbusy=%b valid=%b want 1 1", MulBusy, OutValid);
    end
    nReset = 1'b0;
    #1;
    model_reset();
    total++;
    if (OutValid !== 1'b0 || obs !== reset_dec() || MulBusy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: valid=%b fields=%h mulbusy=%b want 0 %h 0",
               OutValid, obs, MulBusy, reset_dec());
    end
    @(negedge Clk);
    nReset = 1'b1;
    drive(1, 16'hE300, 1, 0);
    total++;
    if (InReady !== 1'b1) begin
      bad++; $display("FAIL reset_clears_mul: InReady=%b want 1", InReady);
    end
    tick();
    total++;
    if (OutValid !== 1'b1 || obs !== ref_decode(16'hE300)) begin
      bad++; $display("FAIL reset_first_capture: valid=%b fields=%h want 1 %h",
                      OutValid, obs, ref_decode(16'hE300));
    end
  endtask

  task automatic test_addi();
    logic [15:0] w;
    drive(1, 16'h9A53, 1, 0);
    total++;
    if (InReady !== 1'b1) begin
      bad++; $display("FAIL addi_ready: got %b want 1", InReady);
    end
    tick();
    total++;
    if (OutValid !== 1'b1 || OpC !== 4'hA || OpB !== 4'h5 || OpA !== 4'h3 ||
        AddrImm !== 12'hA53 || IsImm !== 1'b1 || HasWB !== 1'b1 || OpULA !== 4'd0) begin
      bad++;
      $display("FAIL addi_fields: valid=%b C=%h B=%h A=%h imm=%h isimm=%b wb=%b ula=%0d want 1 A 5 3 A53 1 1 0",
               OutValid, OpC, OpB, OpA, AddrImm, IsImm, HasWB, OpULA);
    end
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 10));
      drive(1, w, 1, 0);
      total++;
      if (InReady !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, InReady);
      end
      tick();
      total++;
      if (OutValid !== 1'b1 || obs !== ref_decode(w)) begin
        bad++; $display("FAIL b2b_fields[%0d]: valid=%b fields=%h want 1 %h", i, OutValid, obs, ref_decode(w));
      end
    end
  endtask

  task automatic test_jump();
    int cnt;
    bit done;
    drive(1, 16'hB010, 1, 0);
    tick();
    total++;
    if (IsJump !== 1'b1 || HasWB !== 1'b0 || OutValid !== 1'b1) begin
      bad++; $display("FAIL jump_flags: isjump=%b haswb=%b valid=%b want 1 0 1", IsJump, HasWB, OutValid);
    end
    cnt = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(1, 16'h0123, 1, 0);
      if (InReady === 1'b1) done = 1;
      else begin cnt++; tick(); end
    end
    total++;
    if (!done || cnt != BR_BUBBLES) begin
      bad++; $display("FAIL jump_bubbles: blocked=%0d cycles (released=%0d) want %0d", cnt, done, BR_BUBBLES);
    end
    tick();
    total++;
    if (obs !== ref_decode(16'h0123)) begin
      bad++; $display("FAIL jump_after: fields=%h want %h", obs, ref_decode(16'h0123));
    end
  endtask

  task automatic test_jump_flush();
    drive(1, 16'hB010, 1, 0);
    tick();
    drive(1, 16'h0456, 0, 1);
    total++;
    if (InReady !== 1'b0) begin
      bad++; $display("FAIL flush_blocks: InReady=%b want 0", InReady);
    end
    tick();
    total++;
    if (OutValid !== 1'b0) begin
      bad++; $display("FAIL flush_kill: OutValid=%b want 0", OutValid);
    end
    drive(1, 16'h0456, 1, 0);
    total++;
    if (InReady !== 1'b1) begin
      bad++; $display("FAIL flush_resume: InReady=%b want 1", InReady);
    end
    tick();
    total++;
    if (OutValid !== 1'b1 || obs !== ref_decode(16'h0456)) begin
      bad++; $display("FAIL flush_capture: valid=%b fields=%h want 1 %h", OutValid, obs, ref_decode(16'h0456));
    end
  endtask

  task automatic test_mul_ghi();
    int cnt;
    bit done;
    drive(1, 16'hD021, 1, 0);
    total++;
    if (InReady !== 1'b1) begin
      bad++; $display("FAIL mul_ready: got %b want 1", InReady);
    end
    tick();
    cnt = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(1, 16'hE300, 1, 0);
      if (InReady === 1'b1) done = 1;
      else begin
        total++;
        if (MulBusy !== 1'b1) begin
          bad++; $display("FAIL mul_busy[%0d]: got %b want 1", i, MulBusy);
        end
        cnt++;
        tick();
      end
    end
    total++;
    if (!done || cnt != MUL_LAT) begin
      bad++; $display("FAIL ghi_held: blocked=%0d cycles (released=%0d) want %0d", cnt, done, MUL_LAT);
    end
    tick();
    total++;
    if (StoreHiLo !== 1'b1 || HiLo !== 1'b1 || HasWB !== 1'b1 || OutValid !== 1'b1 || MulBusy !== 1'b0) begin
      bad++; $display("FAIL ghi_capture: storehilo=%b hilo=%b wb=%b valid=%b mulbusy=%b want 1 1 1 1 0",
                      StoreHiLo, HiLo, HasWB, OutValid, MulBusy);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 16'h1111, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h2222, 0, 0);
      total++;
      if (InReady !== 1'b0) begin
        bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, InReady);
      end
      tick();
      total++;
      if (OutValid !== 1'b1 || obs !== ref_decode(16'h1111)) begin
        bad++; $display("FAIL bp_hold[%0d]: valid=%b fields=%h want 1 %h", i, OutValid, obs, ref_decode(16'h1111));
      end
    end
    drive(1, 16'h2222, 1, 0);
    total++;
    if (InReady !== 1'b1) begin
      bad++; $display("FAIL bp_release: InReady=%b want 1", InReady);
    end
    tick();
    total++;
    if (OutValid !== 1'b1 || obs !== ref_decode(16'h2222)) begin
      bad++; $display("FAIL bp_replace: valid=%b fields=%h want 1 %h", OutValid, obs, ref_decode(16'h2222));
    end
    drive(0, 16'h3333, 1, 0);
    tick();
    total++;
    if (OutValid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: OutValid=%b want 0", OutValid);
    end
  endtask

  task automatic test_random();
    bit          v, ordy, fl;
    logic [15:0] w;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom % 4) != 0;
      ordy = ($urandom % 4) != 0;
      fl   = ($urandom % 16) == 0;
      w    = 16'($urandom);
      drive(v, w, ordy, fl);
      total++;
      if (InReady !== m_ready) begin
        bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, InReady, m_ready);
      end
      tick();
      total++;
      if (OutValid !== (m_ov != 0)) begin
        bad++; $display("FAIL rand_valid[%0d]: got %b want %0d", i, OutValid, m_ov);
      end
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL rand_fields[%0d]: got %h want %h", i, obs, m_out);
      end
      total++;
      if (MulBusy !== (m_mul > 0)) begin
        bad++; $display("FAIL rand_mulbusy[%0d]: got %b want %0d", i, MulBusy, m_mul > 0);
      end
      total++;
      if (StallCnt !== 16'(m_stall)) begin
        bad++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, StallCnt, m_stall);
      end
    end
  endtask

  task automatic test_stall_cnt();
    nReset = 1'b0;
    #1;
    model_reset();
    @(negedge Clk);
    nReset = 1'b1;
    drive(1, 16'h1111, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'h2222, 0, 0);
      tick();
    end
`ifdef DECODE_STALL_CNT_EN
    total++;
    if (StallCnt !== 16'd5) begin
      bad++; $display("FAIL stall_five: got %0d want 5", StallCnt);
    end
    for (int i = 0; i < 65600; i++) begin
      drive(1, 16'h2222, 0, 0);
      tick();
    end
    total++;
    if (StallCnt !== 16'hFFFF) begin
      bad++; $display("FAIL stall_saturate: got %h want FFFF", StallCnt);
    end
`else
    total++;
    if (StallCnt !== 16'h0000) begin
      bad++; $display("FAIL stall_disabled: got %h want 0000", StallCnt);
    end
`endif
  endtask

  initial begin
    nReset = 1'b0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0; Instr = '0;
    model_reset();
    test_reset();
    test_addi();
    test_jump();
    test_jump_flush();
    test_mul_ghi();
    test_backpressure();
    test_random();
    test_stall_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
